// File: rtl/halfband_27_interp_pkg.sv
// Shared constants, coefficient table and output rounding
// for the 8-channel 27-tap halfband 2x interpolator.
package halfband_27_interp_pkg;

  localparam int NCH    = 8;
  localparam int W      = 24;
  localparam int COEF_W = 18;
  localparam int ACC_W  = 48;
  localparam int QSHIFT = 17;
  localparam int NPAIR  = 7;
  localparam int BUF_N  = 32;
  localparam int AW     = 5;

  localparam int LAT_EVEN = 6;
  localparam int LAT_ODD  = 14;

  localparam logic [3:0] FILL_MAX   = 4'd14;
  localparam logic [3:0] CENTER_OFS = 4'd7;

  // Entries 0..6 are the pair taps, entry 7 the center tap.
  localparam logic signed [COEF_W-1:0] COEF [NPAIR+1] = '{
    18'sd44, -18'sd264, 18'sd1073, -18'sd3357,
    18'sd8856, -18'sd22204, 18'sd81391, 18'sd131069
  };

  localparam logic signed [ACC_W-1:0] RND_HALF = 48'sd65536;
  localparam logic signed [ACC_W-1:0] SAT_MAX  = 48'sd8388607;
  localparam logic signed [ACC_W-1:0] SAT_MIN  = -48'sd8388608;

  function automatic logic [W-1:0] rnd_sat(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [ACC_W-1:0] r;
    r = (a + RND_HALF) >>> QSHIFT;
    if (r > SAT_MAX) r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
    return r[W-1:0];
  endfunction

endpackage

// File: rtl/halfband_27_interp_mac.sv
// Per-channel pre-add / multiply / accumulate slice:
// acc = (clr ? 0 : acc) + (a + b) * coef when enabled.
module preadd_mac_24x18
  import halfband_27_interp_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic signed [W-1:0]      a_i,
  input  logic signed [W-1:0]      b_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  localparam int PW = W + 1 + COEF_W;

  logic signed [W:0]       pre;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    pre   = (W+1)'(a_i) + (W+1)'(b_i);
    prod  = PW'(pre) * PW'(coef_i);
    base  = clr_i ? '0 : acc_q;
    acc_d = acc_q;
    if (en_i) acc_d = base + ACC_W'(prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/halfband_27_interp.sv
// 8-channel halfband 2x interpolator: sequencing, history
// buffer addressing and coefficient ROM; one MAC per lane.
module halfband_27_interp
  import halfband_27_interp_pkg::*;
(
  input  logic             c,
  input  logic             reset_n,
  input  logic [NCH*W-1:0] id,
  input  logic             iv,
  output logic [NCH*W-1:0] od,
  output logic             ov,
  output logic             ovf
);

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_CTR  = 4'd1;
  localparam logic [3:0] ST_P0   = 4'd2;
  localparam logic [3:0] ST_PL   = 4'd8;
  localparam logic [3:0] ST_EV   = 4'(LAT_EVEN - 1);
  localparam logic [3:0] ST_OD   = 4'(LAT_ODD - 1);

  logic [3:0]       st_q, st_d;
  logic [AW-1:0]    wp_q, wp_d;
  logic [3:0]       fill_q, fill_d;
  logic             ovf_q, ovf_d;
  logic             ov_q, ov_d;
  logic [NCH*W-1:0] od_q, od_d;
  logic [NCH*W-1:0] ev_q, ev_d;
  logic [NCH*W-1:0] rs_w;
  logic [NCH*W-1:0] buf_q [BUF_N];

  logic             take;
  logic             acc_en, acc_clr, use_b;
  logic [2:0]       pj;
  logic [3:0]       m_a, m_b;
  logic             ok_a, ok_b;
  logic [AW-1:0]    ra, rb;
  logic [NCH*W-1:0] xa, xb;
  logic signed [COEF_W-1:0] coef;

  always_comb begin
    take    = iv && (st_q == ST_IDLE);
    st_d    = st_q;
    wp_d    = wp_q;
    fill_d  = fill_q;
    ovf_d   = ovf_q;
    acc_en  = 1'b0;
    acc_clr = 1'b0;
    use_b   = 1'b0;
    pj      = 3'(st_q - ST_P0);
    m_a     = 4'd0;
    m_b     = 4'd0;
    coef    = '0;
    if (st_q == ST_IDLE) begin
      if (iv) begin
        st_d = ST_CTR;
        wp_d = wp_q + 1'b1;
        if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
      end
    end else begin
      st_d = st_q + 1'b1;
      if (iv) ovf_d = 1'b1;
    end
    unique case (1'b1)
      (st_q == ST_CTR): begin
        acc_en  = 1'b1;
        acc_clr = 1'b1;
        m_a     = CENTER_OFS;
        coef    = COEF[NPAIR];
      end
      (st_q >= ST_P0 && st_q <= ST_PL): begin
        acc_en  = 1'b1;
        acc_clr = (st_q == ST_P0);
        use_b   = 1'b1;
        m_a     = {1'b0, pj};
        m_b     = 4'd13 - {1'b0, pj};
        coef    = COEF[pj];
      end
      default: ;
    endcase
  end

  // Newest sample sits at wp-1 once the accept edge has passed.
  always_comb begin
    ok_a = (m_a < fill_q);
    ok_b = use_b && (m_b < fill_q);
    ra   = wp_q - 1'b1 - AW'(m_a);
    rb   = wp_q - 1'b1 - AW'(m_b);
    xa   = ok_a ? buf_q[ra] : '0;
    xb   = ok_b ? buf_q[rb] : '0;
  end

  always_comb begin
    ev_d = ev_q;
    od_d = od_q;
    ov_d = 1'b0;
    if (st_q == ST_P0) ev_d = rs_w;
    if (st_q == ST_EV) begin
      od_d = ev_q;
      ov_d = 1'b1;
    end
    if (st_q == ST_OD) begin
      od_d = rs_w;
      ov_d = 1'b1;
    end
  end

  always_ff @(posedge c) begin
    if (take) buf_q[wp_q] <= id;
  end

  always_ff @(posedge c or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= ST_IDLE;
      wp_q   <= '0;
      fill_q <= '0;
      ovf_q  <= 1'b0;
      ov_q   <= 1'b0;
      od_q   <= '0;
      ev_q   <= '0;
    end else begin
      st_q   <= st_d;
      wp_q   <= wp_d;
      fill_q <= fill_d;
      ovf_q  <= ovf_d;
      ov_q   <= ov_d;
      od_q   <= od_d;
      ev_q   <= ev_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic signed [ACC_W-1:0] acc;
    preadd_mac_24x18 u_mac (
      .clk    (c),
      .rst_n  (reset_n),
      .en_i   (acc_en),
      .clr_i  (acc_clr),
      .a_i    (xa[k*W +: W]),
      .b_i    (xb[k*W +: W]),
      .coef_i (coef),
      .acc_o  (acc)
    );
    assign rs_w[k*W +: W] = rnd_sat(acc);
  end

  assign od  = od_q;
  assign ov  = ov_q;
  assign ovf = ovf_q;

endmodule
